// File: rtl/mac_tx_framer_if.sv
// Request, payload and MAC transmit stream signals of mac_tx_framer.
// The vlan_tci field exists only when MAC_TX_FRAMER_VLAN_EN is defined.
interface mac_tx_framer_if;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
`ifdef MAC_TX_FRAMER_VLAN_EN
    logic [15:0] vlan_tci;
`endif
    logic        pl_valid;
    logic [7:0]  pl_data;
    logic        pl_ready;
    logic        tx_busy;
    logic        err_len;
    logic        err_underrun;
    logic        mac_tx_sof;
    logic        mac_tx_eof;
    logic        mac_tx_valid;
    logic [7:0]  mac_tx_data;

    modport master (
`ifdef MAC_TX_FRAMER_VLAN_EN
        output vlan_tci,
`endif
        output tx_start, tx_len, dst_mac, src_mac, eth_type, pl_valid, pl_data,
        input  pl_ready, tx_busy, err_len, err_underrun,
        input  mac_tx_sof, mac_tx_eof, mac_tx_valid, mac_tx_data
    );

    modport slave (
`ifdef MAC_TX_FRAMER_VLAN_EN
        input  vlan_tci,
`endif
        input  tx_start, tx_len, dst_mac, src_mac, eth_type, pl_valid, pl_data,
        output pl_ready, tx_busy, err_len, err_underrun,
        output mac_tx_sof, mac_tx_eof, mac_tx_valid, mac_tx_data
    );
endinterface

// File: rtl/mac_tx_framer.sv
// Ethernet II frame builder for the RGMII MAC tx stream: header, payload, zero pad, gap.
// Defining MAC_TX_FRAMER_VLAN_EN inserts an 802.1Q tag (0x8100 + vlan_tci) before eth_type.
module mac_tx_framer #(
    parameter int MIN_FRAME   = 60,
    parameter int MAX_PAYLOAD = 1500,
    parameter int GAP_CYCLES  = 24
) (
    input  logic           mac_tx_clk,
    input  logic           rst,
    mac_tx_framer_if.slave bus
);
`ifdef MAC_TX_FRAMER_VLAN_EN
    localparam int HDR_LEN = 18;
`else
    localparam int HDR_LEN = 14;
`endif
    localparam int               HDR_BITS = 8 * HDR_LEN;
    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [10:0]      MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [10:0]      MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0]      HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, HDR, PAY, PAD, GAP} state_t;

    state_t              state_q, state_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_d, hdr_new;
    logic [10:0]         cnt_q, cnt_d, cnt_inc;
    logic [10:0]         pay_left_q, pay_left_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                len_ok;

    logic       mid_valid_q, mid_valid_d, mid_sof_q, mid_sof_d, mid_eof_q, mid_eof_d;
    logic [7:0] mid_data_q, mid_data_d;
    logic       out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic [7:0] out_data_q, out_data_d;
    logic       pl_ready_q, pl_ready_d, tx_busy_q, tx_busy_d;
    logic       err_len_q, err_len_d, err_underrun_q, err_underrun_d;

`ifdef MAC_TX_FRAMER_VLAN_EN
    assign hdr_new = {bus.dst_mac, bus.src_mac, 16'h8100, bus.vlan_tci, bus.eth_type};
`else
    assign hdr_new = {bus.dst_mac, bus.src_mac, bus.eth_type};
`endif
    assign len_ok  = (bus.tx_len != 11'd0) && (bus.tx_len <= MAX_LEN);
    assign cnt_inc = cnt_q + 11'd1;

    // cnt_q is the index of the byte being issued into the mid stage this cycle;
    // the mid stage gives payload bytes their one-cycle accept-to-output delay.
    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        cnt_d          = cnt_q;
        pay_left_d     = pay_left_q;
        gap_d          = gap_q;
        mid_valid_d    = 1'b0;
        mid_sof_d      = 1'b0;
        mid_eof_d      = 1'b0;
        mid_data_d     = 8'h00;
        err_len_d      = 1'b0;
        err_underrun_d = 1'b0;
        tx_busy_d      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                cnt_d = 11'd0;
                gap_d = '0;
                if (bus.tx_start) begin
                    if (len_ok) begin
                        state_d     = HDR;
                        hdr_d       = {hdr_new[HDR_BITS-9:0], 8'h00};
                        pay_left_d  = bus.tx_len;
                        cnt_d       = 11'd1;
                        mid_valid_d = 1'b1;
                        mid_sof_d   = 1'b1;
                        mid_data_d  = hdr_new[HDR_BITS-1 -: 8];
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            HDR: begin
                mid_valid_d = 1'b1;
                mid_data_d  = hdr_q[HDR_BITS-1 -: 8];
                hdr_d       = {hdr_q[HDR_BITS-9:0], 8'h00};
                cnt_d       = cnt_inc;
                if (cnt_q == HDR_LAST) state_d = PAY;
            end
            PAY: begin
                mid_valid_d    = 1'b1;
                mid_data_d     = bus.pl_valid ? bus.pl_data : 8'h00;
                err_underrun_d = ~bus.pl_valid;
                cnt_d          = cnt_inc;
                pay_left_d     = pay_left_q - 11'd1;
                if (pay_left_q == 11'd1) begin
                    if (cnt_inc >= MIN_LEN) begin
                        mid_eof_d = 1'b1;
                        state_d   = GAP;
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                mid_valid_d = 1'b1;
                cnt_d       = cnt_inc;
                if (cnt_inc >= MIN_LEN) begin
                    mid_eof_d = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                cnt_d = 11'd0;
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_d     = '0;
                    tx_busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = mid_valid_q;
        out_sof_d   = mid_sof_q;
        out_eof_d   = mid_eof_q;
        out_data_d  = mid_data_q;
        pl_ready_d  = (state_d == PAY);
    end

    always_ff @(posedge mac_tx_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hdr_q          <= '0;
            cnt_q          <= 11'd0;
            pay_left_q     <= 11'd0;
            gap_q          <= '0;
            mid_valid_q    <= 1'b0;
            mid_sof_q      <= 1'b0;
            mid_eof_q      <= 1'b0;
            mid_data_q     <= 8'h00;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            out_data_q     <= 8'h00;
            pl_ready_q     <= 1'b0;
            tx_busy_q      <= 1'b0;
            err_len_q      <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hdr_q          <= hdr_d;
            cnt_q          <= cnt_d;
            pay_left_q     <= pay_left_d;
            gap_q          <= gap_d;
            mid_valid_q    <= mid_valid_d;
            mid_sof_q      <= mid_sof_d;
            mid_eof_q      <= mid_eof_d;
            mid_data_q     <= mid_data_d;
            out_valid_q    <= out_valid_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            out_data_q     <= out_data_d;
            pl_ready_q     <= pl_ready_d;
            tx_busy_q      <= tx_busy_d;
            err_len_q      <= err_len_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign bus.mac_tx_valid = out_valid_q;
    assign bus.mac_tx_sof   = out_sof_q;
    assign bus.mac_tx_eof   = out_eof_q;
    assign bus.mac_tx_data  = out_data_q;
    assign bus.pl_ready     = pl_ready_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.err_len      = err_len_q;
    assign bus.err_underrun = err_underrun_q;
endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: expected frame bytes are queued when a
// request is driven and popped as the MAC stream produces them.
module tb_mac_tx_framer;
    localparam int MIN_FRAME   = 60;
    localparam int MAX_PAYLOAD = 1500;
    localparam int GAP_CYCLES  = 24;
`ifdef MAC_TX_FRAMER_VLAN_EN
    localparam int HDR_LEN = 18;
`else
    localparam int HDR_LEN = 14;
`endif
    localparam logic [15:0] TCI = 16'hE00A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    mac_tx_framer_if bus ();

    mac_tx_framer #(
        .MIN_FRAME  (MIN_FRAME),
        .MAX_PAYLOAD(MAX_PAYLOAD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .mac_tx_clk(clk),
        .rst       (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] sbq[$];
    int starveLo = 0, starveHi = 0;
    int readyCnt = 0, underrunCnt = 0, errLenCnt = 0, validCnt = 0, busyCnt = 0, sofCnt = 0;
    int curLen = 0, lastLen = 0, lastGap = -1, lowRun = 0;
    bit gapArmed = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int expLen(input int len);
        return (HDR_LEN + len < MIN_FRAME) ? MIN_FRAME : HDR_LEN + len;
    endfunction

    task automatic pushFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                             input int len, input int sLo, input int sHi);
        logic [7:0] b[$];
        int k = 0;
        for (int i = 5; i >= 0; i--) b.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(src[8*i +: 8]);
`ifdef MAC_TX_FRAMER_VLAN_EN
        b.push_back(8'h81);
        b.push_back(8'h00);
        b.push_back(TCI[15:8]);
        b.push_back(TCI[7:0]);
`endif
        b.push_back(typ[15:8]);
        b.push_back(typ[7:0]);
        for (int s = 0; s < len; s++) begin
            if (s >= sLo && s < sHi) b.push_back(8'h00);
            else begin
                b.push_back(k[7:0]);
                k++;
            end
        end
        while (b.size() < MIN_FRAME) b.push_back(8'h00);
        for (int i = 0; i < b.size(); i++) sbq.push_back({(i == 0), (i == b.size() - 1), b[i]});
    endtask

    task automatic driveRequest(input int len, input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ);
        bus.tx_len   = len[10:0];
        bus.dst_mac  = dst;
        bus.src_mac  = src;
        bus.eth_type = typ;
`ifdef MAC_TX_FRAMER_VLAN_EN
        bus.vlan_tci = TCI;
`endif
    endtask

    task automatic applyStimulus(input int len, input logic [47:0] dst, input logic [47:0] src,
                                 input logic [15:0] typ, input bit accept);
        if (accept) pushFrame(dst, src, typ, len, starveLo, starveHi);
        @(negedge clk);
        driveRequest(len, dst, src, typ);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        checkOutput("err_len_pulse", bus.err_len, accept ? 0 : 1);
        @(negedge clk);
        checkOutput("busy_after_start", bus.tx_busy, accept ? 1 : 0);
        checkOutput("sof_latency", bus.mac_tx_sof, accept ? 1 : 0);
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while ((sbq.size() != 0 || bus.tx_busy) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", (n < maxCycles) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard pop plus event counters, sampled on the falling edge.
    initial begin
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            if (bus.pl_ready) readyCnt++;
            if (bus.err_underrun) underrunCnt++;
            if (bus.err_len) errLenCnt++;
            if (bus.tx_busy) busyCnt++;
            if (bus.mac_tx_valid) begin
                validCnt++;
                if (bus.mac_tx_sof) begin
                    sofCnt++;
                    curLen = 1;
                    if (gapArmed) lastGap = lowRun;
                end else begin
                    curLen++;
                end
                lowRun = 0;
                if (bus.mac_tx_eof) begin
                    lastLen  = curLen;
                    gapArmed = 1'b1;
                end
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_byte", 0, 1);
                end else begin
                    exp = sbq.pop_front();
                    checkOutput("byte", {bus.mac_tx_sof, bus.mac_tx_eof, bus.mac_tx_data}, exp);
                end
            end else begin
                lowRun++;
            end
        end
    end

    // Payload source: sequential bytes per frame, withholding the starve slot window.
    initial begin
        int slot;
        int srcIdx;
        bit lastReady;
        bit lastValid;
        slot = 0;
        srcIdx = 0;
        lastReady = 1'b0;
        lastValid = 1'b0;
        bus.pl_valid = 1'b0;
        bus.pl_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (lastReady) begin
                slot++;
                if (lastValid) srcIdx++;
            end
            if (bus.mac_tx_sof) begin
                slot = 0;
                srcIdx = 0;
            end
            if (slot >= starveLo && slot < starveHi) begin
                bus.pl_valid = 1'b0;
                bus.pl_data  = 8'hA5;
            end else begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = srcIdx[7:0];
            end
            lastReady = bus.pl_ready;
            lastValid = bus.pl_valid;
        end
    end

    initial begin
        int r0, u0, e0, v0, b0, s0, n, cnt;
        bus.tx_start = 1'b0;
        driveRequest(0, 48'h0, 48'h0, 16'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", bus.mac_tx_valid, 0);
        checkOutput("rst_sof", bus.mac_tx_sof, 0);
        checkOutput("rst_eof", bus.mac_tx_eof, 0);
        checkOutput("rst_data", bus.mac_tx_data, 0);
        checkOutput("rst_pl_ready", bus.pl_ready, 0);
        checkOutput("rst_busy", bus.tx_busy, 0);
        checkOutput("rst_err_len", bus.err_len, 0);
        checkOutput("rst_err_underrun", bus.err_underrun, 0);
        rst = 1'b0;

        $display("[TB] basic frame");
        r0 = readyCnt; u0 = underrunCnt; e0 = errLenCnt;
        applyStimulus(100, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 1'b1);
        waitIdle(2000);
        checkOutput("basic_len", lastLen, expLen(100));
        checkOutput("basic_ready", readyCnt - r0, 100);
        checkOutput("basic_underrun", underrunCnt - u0, 0);
        checkOutput("basic_err_len", errLenCnt - e0, 0);

        $display("[TB] padding");
        r0 = readyCnt;
        applyStimulus(10, 48'h0A0B_0C0D_0E0F, 48'h0200_0000_0002, 16'h88B5, 1'b1);
        waitIdle(2000);
        checkOutput("pad_len", lastLen, MIN_FRAME);
        checkOutput("pad_ready", readyCnt - r0, 10);

        $display("[TB] length boundaries");
        applyStimulus(1, 48'h1122_3344_5566, 48'h0200_0000_0003, 16'h86DD, 1'b1);
        waitIdle(2000);
        checkOutput("len1_len", lastLen, MIN_FRAME);
        applyStimulus(MAX_PAYLOAD, 48'h0200_0000_00AA, 48'h0200_0000_0004, 16'h0806, 1'b1);
        waitIdle(4000);
        checkOutput("max_len", lastLen, expLen(MAX_PAYLOAD));

        $display("[TB] length reject");
        e0 = errLenCnt; v0 = validCnt; b0 = busyCnt;
        applyStimulus(0, 48'h0200_0000_00BB, 48'h0200_0000_0005, 16'h0800, 1'b0);
        applyStimulus(MAX_PAYLOAD + 1, 48'h0200_0000_00CC, 48'h0200_0000_0006, 16'h0800, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("reject_err_len", errLenCnt - e0, 2);
        checkOutput("reject_valid", validCnt - v0, 0);
        checkOutput("reject_busy", busyCnt - b0, 0);

        $display("[TB] underrun");
        r0 = readyCnt; u0 = underrunCnt;
        starveLo = 20; starveHi = 23;
        applyStimulus(64, 48'h0200_0000_00DD, 48'h0200_0000_0007, 16'h0800, 1'b1);
        waitIdle(2000);
        starveLo = 0; starveHi = 0;
        checkOutput("underrun_len", lastLen, expLen(64));
        checkOutput("underrun_pulses", underrunCnt - u0, 3);
        checkOutput("underrun_ready", readyCnt - r0, 64);

        $display("[TB] back-to-back");
        pushFrame(48'h0200_0000_00EE, 48'h0200_0000_0008, 16'h0800, 10, 0, 0);
        pushFrame(48'h0200_0000_00EE, 48'h0200_0000_0008, 16'h0800, 10, 0, 0);
        s0 = sofCnt;
        lastGap = -1;
        @(negedge clk);
        driveRequest(10, 48'h0200_0000_00EE, 48'h0200_0000_0008, 16'h0800);
        bus.tx_start = 1'b1;
        n = 0;
        while (sofCnt < s0 + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        bus.tx_start = 1'b0;
        checkOutput("b2b_timeout", (n < 1000) ? 1 : 0, 1);
        waitIdle(2000);
        checkOutput("b2b_gap", lastGap, GAP_CYCLES);
        checkOutput("b2b_sofs", sofCnt - s0, 2);

        $display("[TB] reset mid-payload");
        applyStimulus(64, 48'h0200_0000_0011, 48'h0200_0000_0009, 16'h0800, 1'b1);
        n = 0; cnt = 0;
        while (cnt < HDR_LEN + 20 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.mac_tx_valid) cnt++;
        end
        checkOutput("reset_wait", cnt, HDR_LEN + 20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid", bus.mac_tx_valid, 0);
        checkOutput("midrst_sof", bus.mac_tx_sof, 0);
        checkOutput("midrst_eof", bus.mac_tx_eof, 0);
        checkOutput("midrst_data", bus.mac_tx_data, 0);
        checkOutput("midrst_busy", bus.tx_busy, 0);
        checkOutput("midrst_pl_ready", bus.pl_ready, 0);
        rst = 1'b0;
        sbq.delete();
        applyStimulus(20, 48'h0200_0000_0022, 48'h0200_0000_000A, 16'h0800, 1'b1);
        waitIdle(2000);
        checkOutput("post_reset_len", lastLen, MIN_FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
